// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: opcodes, address width and the bus FSM state enum.
// Used by both the qspi master and the qspi_target device model.
package qspi_pkg;

    localparam logic [7:0] QSPI_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] QSPI_CMD_QWRITE = 8'h38;
    localparam int         QSPI_ADDR_BITS  = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } qspi_state_e;

endpackage

// File: rtl/qspi_target_mem.sv
// Byte storage for qspi_target: 2^AW x 8 array with one synchronous read
// port (1-clk latency, output held between reads) and one write port.
// Contents are not part of any reset.
module qspi_target_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] mem_r [DEPTH];
    logic [7:0] rd_data_r;

    // Byte write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read; the last fetched byte is held until the next fetch.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/qspi_target.sv
// qspi_target: QSPI memory target answering quad read (EBh) and quad write
// (38h) from the qspi cache-fill master. Nibbles are sampled on sck rise and
// driven on sck fall; sck is oversampled by clk.
// Optional feature macro: QSPI_TARGET_WRAP_EN -- when defined, the byte
// pointer increments within its LINE_LENGTH-aligned block (critical-word-first
// line fills); otherwise it increments linearly and wraps at 2^AW.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int AW          = 12,
    parameter int DUMMY       = 6,
    parameter int LINE_LENGTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic [3:0] io_in,
    output logic [3:0] io_out,
    output logic [3:0] io_oe
);

    localparam logic [3:0]    ADDR_LAST  = 4'(QSPI_ADDR_BITS / 4 - 1);
    localparam logic [3:0]    DUMMY_LAST = 4'(DUMMY - 1);
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
`ifdef QSPI_TARGET_WRAP_EN
    localparam logic [AW-1:0] LINE_MASK  = AW'(LINE_LENGTH - 1);
`endif

    qspi_state_e   state_r;
    logic          sck_q_r;
    logic          cs_q_r;
    logic [3:0]    cnt_r;
    logic          half_r;
    logic          is_read_r;
    logic [3:0]    op_hi_r;
    logic [AW-5:0] addr_r;
    logic [AW-1:0] ptr_r;
    logic [3:0]    wr_hi_r;
    logic [3:0]    io_out_r;
    logic [3:0]    io_oe_r;

    logic          rise_s;
    logic          fall_s;
    logic [AW-1:0] addr_shift_s;
    logic [AW-1:0] ptr_inc_s;
    logic          rd_en_s;
    logic [AW-1:0] rd_addr_s;
    logic [7:0]    rd_data_s;
    logic          wr_en_s;
    logic [7:0]    wr_data_s;

    // Next byte pointer: wraps inside the line block or across the whole array.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
`ifdef QSPI_TARGET_WRAP_EN
        return (p & ~LINE_MASK) | ((p + PTR_ONE) & LINE_MASK);
`else
        return p + PTR_ONE;
`endif
    endfunction

    assign rise_s       = !cs_n && !sck_q_r &&  sck;
    assign fall_s       = !cs_n &&  sck_q_r && !sck;
    assign addr_shift_s = {addr_r, io_in};
    assign ptr_inc_s    = ptr_next(ptr_r);
    assign wr_data_s    = {wr_hi_r, io_in};

    // Memory port control: fetch on last address rise and after each low
    // read nibble; write on the second nibble rise of every data byte.
    always_comb begin
        rd_en_s   = 1'b0;
        rd_addr_s = ptr_r;
        wr_en_s   = 1'b0;
        if (reset && !cs_n) begin
            case (state_r)
                ST_ADDR: begin
                    if (rise_s && (cnt_r == ADDR_LAST) && is_read_r) begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = addr_shift_s;
                    end else begin
                        rd_en_s   = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (fall_s && half_r) begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = ptr_inc_s;
                    end else begin
                        rd_en_s   = 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (rise_s && half_r) begin
                        wr_en_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                default: begin
                    rd_en_s = 1'b0;
                    wr_en_s = 1'b0;
                end
            endcase
        end else begin
            rd_en_s = 1'b0;
            wr_en_s = 1'b0;
        end
    end

    // Bus FSM with registered pad outputs. cs_q_r follows cs_n even during
    // reset so a transaction interrupted by reset is ignored until cs_n
    // toggles high and low again.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            sck_q_r   <= 1'b0;
            cs_q_r    <= cs_n;
            cnt_r     <= 4'd0;
            half_r    <= 1'b0;
            is_read_r <= 1'b0;
            op_hi_r   <= 4'h0;
            addr_r    <= '0;
            ptr_r     <= '0;
            wr_hi_r   <= 4'h0;
            io_out_r  <= 4'h0;
            io_oe_r   <= 4'h0;
        end else begin
            sck_q_r <= sck;
            cs_q_r  <= cs_n;
            if (cs_n) begin
                state_r  <= ST_IDLE;
                cnt_r    <= 4'd0;
                half_r   <= 1'b0;
                io_out_r <= 4'h0;
                io_oe_r  <= 4'h0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_q_r) begin
                            state_r <= ST_CMD;
                            cnt_r   <= 4'd0;
                            half_r  <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (rise_s) begin
                            if (cnt_r == 4'd0) begin
                                op_hi_r <= io_in;
                                cnt_r   <= 4'd1;
                            end else begin
                                cnt_r <= 4'd0;
                                if ({op_hi_r, io_in} == QSPI_CMD_QREAD) begin
                                    state_r   <= ST_ADDR;
                                    is_read_r <= 1'b1;
                                end else if ({op_hi_r, io_in} == QSPI_CMD_QWRITE) begin
                                    state_r   <= ST_ADDR;
                                    is_read_r <= 1'b0;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_s) begin
                            if (cnt_r == ADDR_LAST) begin
                                ptr_r   <= addr_shift_s;
                                cnt_r   <= 4'd0;
                                half_r  <= 1'b0;
                                state_r <= is_read_r ? ST_DUMMY : ST_WDATA;
                            end else begin
                                addr_r <= addr_shift_s[AW-5:0];
                                cnt_r  <= cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (rise_s) begin
                            if (cnt_r == DUMMY_LAST) begin
                                state_r <= ST_RDATA;
                                cnt_r   <= 4'd0;
                                half_r  <= 1'b0;
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (fall_s) begin
                            io_oe_r <= 4'hf;
                            if (!half_r) begin
                                io_out_r <= rd_data_s[7:4];
                                half_r   <= 1'b1;
                            end else begin
                                io_out_r <= rd_data_s[3:0];
                                half_r   <= 1'b0;
                                ptr_r    <= ptr_inc_s;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise_s) begin
                            if (!half_r) begin
                                wr_hi_r <= io_in;
                                half_r  <= 1'b1;
                            end else begin
                                half_r <= 1'b0;
                                ptr_r  <= ptr_inc_s;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        io_oe_r <= 4'h0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    qspi_target_mem #(.AW(AW)) u_mem (
        .clk     (clk),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s),
        .wr_en   (wr_en_s),
        .wr_addr (ptr_r),
        .wr_data (wr_data_s)
    );

    assign io_out = io_out_r;
    assign io_oe  = io_oe_r;

endmodule

// File: tb/tb_qspi_target.sv
// Testbench for qspi_target: vector table of write/read transactions,
// hand-written corner sequences and randomized traffic against a byte-array
// reference model. Honours QSPI_TARGET_WRAP_EN like the design.
`timescale 1ns/1ps
module tb_qspi_target;
    import qspi_pkg::*;

    localparam int AW          = 12;
    localparam int DUMMY       = 6;
    localparam int LINE_LENGTH = 4;
    localparam int MEMSZ       = 1 << AW;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       sck   = 1'b0;
    logic       cs_n  = 1'b1;
    logic [3:0] io_in = 4'h0;
    logic [3:0] io_out;
    logic [3:0] io_oe;

    qspi_target #(.AW(AW), .DUMMY(DUMMY), .LINE_LENGTH(LINE_LENGTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .sck    (sck),
        .cs_n   (cs_n),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [2:0]  n;
        logic [31:0] d;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_mem [MEMSZ];
    bit         known [MEMSZ];
    logic [7:0] wr_buf [64];
    logic [7:0] rd_buf [64];
    logic [3:0] cap_out;
    logic [3:0] cap_oe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Address of the byte following a, by the pointer increment rule.
    function automatic int model_next(input int a);
`ifdef QSPI_TARGET_WRAP_EN
        int base;
        base = a - (a % LINE_LENGTH);
        return base + ((a - base + 1) % LINE_LENGTH);
`else
        return (a + 1) % MEMSZ;
`endif
    endfunction

    // One sck period; entered at a negedge with sck low. Captures the pads
    // just before the rise, i.e. what the master would sample.
    task automatic bus_cycle(input logic [3:0] nib);
        io_in = nib;
        repeat (2) @(negedge clk);
        cap_out = io_out;
        cap_oe  = io_oe;
        sck = 1'b1;
        repeat (2) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_end(input string name);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        check(name, 32'(io_oe), 32'h0);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        logic [31:0] hdr;
        int p;
        hdr = {QSPI_CMD_QWRITE, a};
        cs_begin();
        for (int i = 7; i >= 0; i--) bus_cycle(hdr[4*i +: 4]);
        p = int'(a[AW-1:0]);
        for (int i = 0; i < n; i++) begin
            bus_cycle(wr_buf[i][7:4]);
            bus_cycle(wr_buf[i][3:0]);
            model_mem[p] = wr_buf[i];
            known[p]     = 1'b1;
            p = model_next(p);
        end
        cs_end("write_release_oe");
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [31:0] hdr;
        logic [3:0]  hi;
        int          oe_bad;
        oe_bad = 0;
        hdr = {QSPI_CMD_QREAD, a};
        cs_begin();
        for (int i = 7; i >= 0; i--) begin
            bus_cycle(hdr[4*i +: 4]);
            if (cap_oe !== 4'h0) oe_bad++;
        end
        for (int i = 0; i < DUMMY; i++) begin
            bus_cycle(4'h0);
            if (cap_oe !== 4'h0) oe_bad++;
        end
        for (int i = 0; i < n; i++) begin
            bus_cycle(4'h0);
            if (cap_oe !== 4'hf) oe_bad++;
            hi = cap_out;
            bus_cycle(4'h0);
            if (cap_oe !== 4'hf) oe_bad++;
            rd_buf[i] = {hi, cap_out};
        end
        check("read_oe_window", oe_bad, 0);
        cs_end("read_release_oe");
    endtask

    task automatic check_read_model(input string name, input logic [23:0] a, input int n);
        int p;
        p = int'(a[AW-1:0]);
        for (int k = 0; k < n; k++) begin
            if (known[p]) check($sformatf("%s_b%0d", name, k), 32'(rd_buf[k]), 32'(model_mem[p]));
            p = model_next(p);
        end
    endtask

    initial begin
        logic [23:0] a;
        int          n;
        int          oe_bad;
        logic [23:0] after_fff;

`ifdef QSPI_TARGET_WRAP_EN
        after_fff = 24'h000FFC;
`else
        after_fff = 24'h000000;
`endif
        vecs[0] = '{1'b1, 24'h000010, 3'd2, 32'hA53C_0000};
        vecs[1] = '{1'b0, 24'h000010, 3'd2, 32'hA53C_0000};
        vecs[2] = '{1'b1, 24'h000FFF, 3'd2, 32'h1122_0000};
        vecs[3] = '{1'b0, after_fff,  3'd1, 32'h2200_0000};
        vecs[4] = '{1'b0, 24'h000FFF, 3'd2, 32'h1122_0000};
        vecs[5] = '{1'b1, 24'h00000C, 3'd4, 32'h1020_3040};
        vecs[6] = '{1'b1, 24'h000010, 3'd2, 32'h5566_0000};
        vecs[7] = '{1'b0, 24'hABC010, 3'd2, 32'h5566_0000};
        vecs[8] = '{1'b0, 24'h00000C, 3'd4, 32'h1020_3040};
`ifdef QSPI_TARGET_WRAP_EN
        vecs[9] = '{1'b0, 24'h00000E, 3'd4, 32'h3040_1020};
`else
        vecs[9] = '{1'b0, 24'h00000E, 3'd4, 32'h3040_5566};
`endif
        for (int i = 0; i < MEMSZ; i++) known[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_oe", 32'(io_oe), 32'h0);
        check("reset_out", 32'(io_out), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                for (int k = 0; k < 4; k++) wr_buf[k] = vecs[i].d[31-8*k -: 8];
                do_write(vecs[i].addr, int'(vecs[i].n));
            end else begin
                do_read(vecs[i].addr, int'(vecs[i].n));
                for (int k = 0; k < int'(vecs[i].n); k++)
                    check($sformatf("vec%0d_byte%0d", i, k), 32'(rd_buf[k]), 32'(vecs[i].d[31-8*k -: 8]));
            end
        end

        // Truncated write: byte 0x20 commits, half byte for 0x21 discarded
        wr_buf[0] = 8'h11;
        wr_buf[1] = 8'h22;
        do_write(24'h000020, 2);
        a = {QSPI_CMD_QWRITE, 16'h0000};
        cs_begin();
        bus_cycle(4'h3); bus_cycle(4'h8);
        for (int i = 0; i < 6; i++) bus_cycle((i == 4) ? 4'h2 : 4'h0);
        bus_cycle(4'h7); bus_cycle(4'hE); bus_cycle(4'h9);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        check("trunc_release_oe", 32'(io_oe), 32'h0);
        @(negedge clk);
        do_read(24'h000020, 2);
        check("trunc_byte20", 32'(rd_buf[0]), 32'h7E);
        check("trunc_byte21", 32'(rd_buf[1]), 32'h22);
        model_mem[32] = 8'h7E;

        // Unknown opcode: bus stays tri-stated, next read works
        cs_begin();
        bus_cycle(4'h9); bus_cycle(4'hF);
        oe_bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus_cycle(4'($urandom_range(0, 15)));
            if (cap_oe !== 4'h0) oe_bad++;
        end
        check("ignore_oe", oe_bad, 0);
        cs_end("ignore_release_oe");
        do_read(24'h000010, 2);
        check_read_model("after_ignore", 24'h000010, 2);

        // Reset during read data
        cs_begin();
        a = 24'h00000E;
        bus_cycle(4'hE); bus_cycle(4'hB);
        for (int i = 5; i >= 0; i--) bus_cycle(a[4*i +: 4]);
        for (int i = 0; i < DUMMY; i++) bus_cycle(4'h0);
        bus_cycle(4'h0);
        check("rst_mid_hi", 32'(cap_out), 32'(model_mem[14][7:4]));
        bus_cycle(4'h0);
        check("rst_mid_lo", 32'(cap_out), 32'(model_mem[14][3:0]));
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_oe", 32'(io_oe), 32'h0);
        check("rst_mid_out", 32'(io_out), 32'h0);
        reset = 1'b1;
        oe_bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus_cycle(4'h0);
            if (cap_oe !== 4'h0) oe_bad++;
        end
        check("rst_mid_ignored", oe_bad, 0);
        cs_end("rst_mid_release_oe");
        do_read(24'h00000C, 4);
        check_read_model("after_reset", 24'h00000C, 4);

        // Randomized traffic in a 64-byte window, random upper address bits
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 4; k++) wr_buf[k] = 8'($urandom);
            do_write({12'($urandom), 12'(256 + 4*b)}, 4);
        end
        for (int t = 0; t < 24; t++) begin
            a = {12'($urandom), 12'(256 + $urandom_range(0, 59))};
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) wr_buf[k] = 8'($urandom);
                do_write(a, n);
            end else begin
                do_read(a, n);
                check_read_model($sformatf("rand%0d", t), a, n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
